// File: rtl/plc_sequencer.sv
// Four-phase instruction sequencer for the IL-style PLC core (FETCH, DECODE, OPERAND, EXEC).
// Fixed 4 cycles per instruction; store-class results are written to data memory during EXEC.
module plc_sequencer #(
  parameter int WIDTH  = 8,
  parameter int IWIDTH = 8,
  parameter int PADDR  = 8,
  parameter int DADDR  = 8,
  parameter logic [IWIDTH-1:0] OP_ST  = 'h02,
  parameter logic [IWIDTH-1:0] OP_STN = 'h03,
  parameter logic [IWIDTH-1:0] OP_S   = 'h04,
  parameter logic [IWIDTH-1:0] OP_R   = 'h05,
  parameter logic [IWIDTH-1:0] OP_ADD = 'h06,
  parameter logic [IWIDTH-1:0] OP_SUB = 'h07
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic [PADDR-1:0]          prog_addr,
  input  logic [IWIDTH+2+DADDR-1:0] prog_rdata,
  output logic [DADDR-1:0]          mem_addr,
  input  logic [WIDTH-1:0]          mem_rdata,
  output logic                      mem_we,
  output logic [WIDTH-1:0]          mem_wdata,
  output logic [IWIDTH-1:0]         alu_op,
  output logic [1:0]                alu_src2,
  output logic [WIDTH-1:0]          alu_a,
  output logic [WIDTH-1:0]          alu_imm,
  output logic                      alu_c_in,
  output logic                      alu_b_in,
  input  logic [WIDTH-1:0]          alu_out,
  input  logic                      alu_c_out,
  input  logic                      alu_b_out,
  input  logic                      alu_flag_valid
);

  localparam int IW = IWIDTH + 2 + DADDR;
  localparam logic [IWIDTH-1:0] OP_HALT = '1;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_OPERAND, S_EXEC
  } state_t;

  state_t            state_q;
  logic [PADDR-1:0]  pc_q;
  logic [IW-1:0]     ir_q;
  logic [WIDTH-1:0]  acc_q;
  logic              carry_q;
  logic              borrow_q;
  logic              busy_q;
  logic              done_q;

  logic [IWIDTH-1:0] op;
  logic [1:0]        src;
  logic [DADDR-1:0]  opnd;
  logic              is_store;
  logic              is_halt;
  logic              in_exec;
  logic              last_instr;

  assign op         = ir_q[IW-1 -: IWIDTH];
  assign src        = ir_q[DADDR +: 2];
  assign opnd       = ir_q[DADDR-1:0];
  assign is_store   = (op == OP_ST) || (op == OP_STN) || (op == OP_S) || (op == OP_R);
  assign is_halt    = (op == OP_HALT);
  assign in_exec    = (state_q == S_EXEC);
  assign last_instr = is_halt || (pc_q == {PADDR{1'b1}});

  // Operand data reaches the ALU directly at the core top; only its timing is owned here.
  logic unused_rdata;
  assign unused_rdata = ^mem_rdata;

  assign busy      = busy_q;
  assign done      = done_q;
  assign prog_addr = pc_q;
  assign mem_addr  = opnd;
  assign alu_op    = op;
  assign alu_src2  = src;
  assign alu_a     = acc_q;
  assign alu_imm   = WIDTH'(opnd);
  assign alu_c_in  = carry_q;
  assign alu_b_in  = borrow_q;

  // The write strobe is gated by rst so an abort mid-EXEC commits nothing on that edge.
  assign mem_we    = in_exec && is_store && !rst;
  assign mem_wdata = (in_exec && is_store) ? alu_out : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      ir_q     <= '0;
      acc_q    <= '0;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            pc_q    <= '0;
            busy_q  <= 1'b1;
            state_q <= S_FETCH;
          end
        end
        S_FETCH:   state_q <= S_DECODE;
        S_DECODE: begin
          ir_q    <= prog_rdata;
          state_q <= S_OPERAND;
        end
        S_OPERAND: state_q <= S_EXEC;
        S_EXEC: begin
          if (!is_halt && !is_store) acc_q <= alu_out;
          if (alu_flag_valid && (op == OP_ADD)) carry_q  <= alu_c_out;
          if (alu_flag_valid && (op == OP_SUB)) borrow_q <= alu_b_out;
          // The top program slot halts like HALT instead of wrapping pc.
          if (last_instr) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            pc_q    <= pc_q + PADDR'(1);
            state_q <= S_FETCH;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/plc_sequencer.md
Name: plc_sequencer

Overview:
- Instruction sequencer for the IL-style PLC core. Fetches instructions from synchronous program memory and fetches operands from synchronous data memory.
- Drives the ALU opcode, operand-B source select and carry/borrow inputs. Owns the current-result accumulator (acc) and the carry and borrow flags.
- Writes store-class results back to data memory.
- Sits between the program ROM, the data RAM and the combinational ALU. The ALU's operand A is always acc, presented on rf_a with source1_choice = 2'b00.

Parameters:
WIDTH, 8, data/accumulator width
IWIDTH, 8, opcode width
PADDR, 8, program address width
DADDR, 8, data address width (operand field of the instruction, also the immediate)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous active-high reset
start  input  1  one-cycle pulse, begin execution at address 0
busy  output  1  high from the cycle after an accepted start until done
done  output  1  one-cycle pulse when the program halts
prog_addr  output  PADDR  program memory address (= pc)
prog_rdata  input  IWIDTH+2+DADDR  instruction word {op[IWIDTH-1:0], src[1:0], operand[DADDR-1:0]}; valid the cycle after prog_addr
mem_addr  output  DADDR  data memory address
mem_rdata  input  WIDTH  data memory read data; valid the cycle after mem_addr
mem_we  output  1  data memory write strobe
mem_wdata  output  WIDTH  data memory write data
alu_op  output  IWIDTH  to ALU op_code
alu_src2  output  2  to ALU source2_choice (operand-B select)
alu_a  output  WIDTH  to ALU rf_a (= acc)
alu_imm  output  WIDTH  to ALU imm_b (operand field, zero-extended)
alu_c_in  output  1  carry flag
alu_b_in  output  1  borrow flag
alu_out  input  WIDTH  ALU result
alu_c_out  input  1  ALU carry out
alu_b_out  input  1  ALU borrow out
alu_flag_valid  input  1  ALU flag outputs are meaningful

Behaviour:
- Clocking and reset: single clock clk; rst is synchronous, active-high, and wins over every other input.
- On rst: state = IDLE; pc, ir, acc, carry and borrow = 0; busy, done and mem_we = 0; all address and data outputs = 0.
- States: IDLE -> FETCH -> DECODE -> OPERAND -> EXEC -> FETCH ... -> IDLE.
- IDLE: start=1 sets pc=0 and moves to FETCH; busy rises next cycle. start is ignored in all other states.
- FETCH: prog_addr = pc.
- DECODE: prog_rdata is latched into ir.
- OPERAND: mem_addr = ir.operand (read issued, used only when ir.src selects word/bit memory).
- EXEC:
  - alu_op = ir.op, alu_src2 = ir.src, alu_imm = ir.operand.
  - mem_rdata feeds the ALU word_mem_b / bit_mem_b inputs.
  - All results are captured at the end of EXEC. Fixed latency is 4 cycles per instruction.
- EXEC, store class (ST, STN, S, R):
  - mem_we = 1 for exactly this cycle; mem_addr = ir.operand; mem_wdata = alu_out.
  - acc is unchanged.
- EXEC, all other opcodes: acc <= alu_out; mem_we = 0.
- Flags:
  - carry <= alu_c_out only when alu_flag_valid = 1 and op = ADD.
  - borrow <= alu_b_out only when alu_flag_valid = 1 and op = SUB.
  - Otherwise both flags hold. Flags persist across instructions, giving multi-word chains.
- HALT opcode (all ones, {IWIDTH{1'b1}}):
  - In EXEC it writes nothing and leaves acc unchanged.
  - done pulses 1 cycle (the cycle after EXEC) and the FSM returns to IDLE; busy falls in the same cycle done rises.
  - acc and flags are retained until the next start. start clears pc only.
- pc increments by 1 at the end of every non-HALT EXEC.
- If the instruction at pc = 2^PADDR-1 is not HALT, it executes normally, then the block halts as for HALT; pc does not wrap.
- Undefined opcodes execute as the ALU default (pass operand A): acc is reloaded with itself and there is no write.
- rst in any state, including mid-EXEC, aborts immediately: no write is committed that edge, and done does not pulse.
- Arithmetic is the ALU's; the sequencer adds no width extension beyond zero-extending the operand into alu_imm.

Test Plan:
- rst held 2 cycles, then released -> all outputs 0, state IDLE, busy=0; a start pulse raises busy on the next cycle.
- Program {LD imm 0x05; ADD imm 0x03; ST addr 0x10; HALT} -> mem_we pulses once with mem_addr=0x10, mem_wdata=0x08; done pulses exactly 16 cycles after start; acc=0x08.
- Carry chain {LD imm 0xFF; ADD imm 0x01; ADD imm 0x00; HALT} -> after instr 2 acc=0x00, carry=1; after instr 3 acc=0x01.
- Word-memory operand: mem[0x20]=0x3C; {LD word 0x20; XOR imm 0xFF; ST 0x21; HALT} -> mem[0x21]=0xC3.
- rst asserted during EXEC of an ST -> no mem_we on that edge, done never pulses, and all registers are 0 the next cycle.
- Program without HALT filling all 2^PADDR slots with NOP-class LD -> halts after the last slot with a single done pulse; start during busy is ignored.
